// File: rtl/debug_pkg.sv
// Shared constants and small types for the debug trigger path: ebreak encoding,
// datapath widths and the register bundles held by the trigger logic.
package debug_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned HIT_CNT_W = 8;

  localparam logic [XLEN-1:0] EBREAK_INST = 32'h00100073;

  typedef struct packed {
    logic            en;
    logic [XLEN-1:0] addr;
  } bp_reg_t;

  // PC of the last trigger, used to step off a breakpoint once.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } skip_reg_t;

  function automatic logic [HIT_CNT_W-1:0] sat_inc(input logic [HIT_CNT_W-1:0] v);
    return (&v) ? v : v + HIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Raw button conditioning: 2-flop synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press (release is silent).
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    pulse_d = stable_q & ~stable_dly_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/debug_trigger_unit.sv
// Debug event source for the debug clock controller: eBreak on ebreak/breakpoint
// retire (with one-shot step-off), plus debounced mode and step button pulses.
module debug_trigger_unit
  import debug_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 btn_mode_raw,
  input  logic                 btn_step_raw,
  input  logic                 retire_valid,
  input  logic [XLEN-1:0]      retire_pc,
  input  logic [XLEN-1:0]      retire_inst,
  input  logic                 bp_we,
  input  logic [XLEN-1:0]      bp_addr_in,
  input  logic                 bp_en_in,
  output logic                 eBreak,
  output logic                 btn1,
  output logic                 btn2,
  output logic [XLEN-1:0]      last_hit_pc,
  output logic [HIT_CNT_W-1:0] hit_count
);

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {btn_step_raw, btn_mode_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk  (clk),
        .rstn (rstn),
        .raw  (btn_raw[gi]),
        .pulse(btn_pulse[gi])
      );
    end
  endgenerate

  assign btn1 = btn_pulse[0];
  assign btn2 = btn_pulse[1];

  bp_reg_t                bp_q, bp_d;
  skip_reg_t              skip_q, skip_d;
  logic                   ebreak_q, ebreak_d;
  logic [XLEN-1:0]        last_hit_pc_q, last_hit_pc_d;
  logic [HIT_CNT_W-1:0]   hit_count_q, hit_count_d;

  logic is_ebreak;
  logic bp_match;
  logic step_off;
  logic trigger;

  // Compare uses the registered breakpoint, so a same-cycle write takes effect next cycle.
  always_comb begin
    is_ebreak = (retire_inst == EBREAK_INST);
    bp_match  = bp_q.en && (retire_pc == bp_q.addr);
    step_off  = skip_q.valid && (retire_pc == skip_q.pc);
    trigger   = retire_valid && (is_ebreak || (bp_match && !step_off));
  end

  always_comb begin
    bp_d = bp_q;
    if (bp_we) begin
      bp_d.en   = bp_en_in;
      bp_d.addr = bp_addr_in;
    end

    // Any retire consumes the step-off window; a new trigger reopens it.
    skip_d = skip_q;
    if (retire_valid) begin
      skip_d.valid = trigger;
      if (trigger) begin
        skip_d.pc = retire_pc;
      end
    end

    ebreak_d      = trigger;
    last_hit_pc_d = trigger ? retire_pc : last_hit_pc_q;
    hit_count_d   = trigger ? sat_inc(hit_count_q) : hit_count_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bp_q          <= '0;
      skip_q        <= '0;
      ebreak_q      <= 1'b0;
      last_hit_pc_q <= '0;
      hit_count_q   <= '0;
    end else begin
      bp_q          <= bp_d;
      skip_q        <= skip_d;
      ebreak_q      <= ebreak_d;
      last_hit_pc_q <= last_hit_pc_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign eBreak      = ebreak_q;
  assign last_hit_pc = last_hit_pc_q;
  assign hit_count   = hit_count_q;

endmodule
